// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and digit helpers for the serial BCD datapath blocks.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bcd_digit_t bcd_nines(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

    function automatic logic bcd_is_valid(input bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: binary add, then +6 correction when the sum passes 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);

    logic [4:0] bin_sum;

    always_comb begin
        bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (bin_sum > {1'b0, BCD_MAX}) begin
            s    = bin_sum[3:0] + BCD_CORR;
            cout = 1'b1;
        end else begin
            s    = bin_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD add/subtract controller: one digit per cycle, LSD first, carry held between digits.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid holds its payload stable until that edge.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4*NDIG-1:0] req_a,
    input  logic [4*NDIG-1:0] req_b,
    input  logic              req_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4*NDIG-1:0] rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_err
);

    localparam int CW = $clog2(NDIG) + 1;
    localparam int W  = 4 * NDIG;

    state_t      state;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic        carry;
    logic        err_q;
    logic [CW-1:0] cnt;

    logic        in_err;
    logic [W-1:0] b_in;
    bcd_digit_t  dig_a;
    bcd_digit_t  dig_b;
    bcd_digit_t  dig_s;
    logic        dig_c;
    logic        last_dig;

    // Subtraction stores the 9's complement of B; the +1 arrives as the initial carry.
    always_comb begin
        in_err = 1'b0;
        b_in   = '0;
        for (int i = 0; i < NDIG; i++) begin
            in_err = in_err | !bcd_is_valid(req_a[4*i +: 4]) | !bcd_is_valid(req_b[4*i +: 4]);
            b_in[4*i +: 4] = req_sub ? bcd_nines(req_b[4*i +: 4]) : req_b[4*i +: 4];
        end
    end

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
                dig_a = a_q[4*i +: 4];
                dig_b = b_q[4*i +: 4];
            end
        end
    end

    assign last_dig = (cnt == CW'(NDIG - 1));

    bcd_digit_add u_digit_add (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry),
        .s    (dig_s),
        .cout (dig_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q       <= req_a;
                        b_q       <= b_in;
                        carry     <= req_sub;
                        err_q     <= in_err;
                        cnt       <= '0;
                        rsp_sum   <= '0;
                        rsp_cout  <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // A bad operand still spends one cycle here so its response appears one edge after accept.
                    if (err_q) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        for (int i = 0; i < NDIG; i++) begin
                            if (cnt == CW'(i)) rsp_sum[4*i +: 4] <= dig_s;
                        end
                        carry <= dig_c;
                        cnt   <= cnt + CW'(1);
                        if (last_dig) begin
                            rsp_cout  <= dig_c;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: directed cases, backpressure, mid-run reset, then random traffic.
module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;
    localparam int EW   = W + 2;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          req_sub;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_sum;
    logic          rsp_cout;
    logic          rsp_err;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic          bp_rand = 1'b0;
    logic          prev_v = 1'b0;

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // reference model: decimal arithmetic on whole numbers
    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int x);
        logic [W-1:0] r = '0;
        int           t = x;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int modv = 10 ** NDIG;
        int av;
        int bv;
        int t;
        if (has_bad(a) || has_bad(b)) return {1'b1, 1'b0, {W{1'b0}}};
        av = bcd2int(a);
        bv = bcd2int(b);
        if (!sub) begin
            t = av + bv;
            return {1'b0, (t >= modv), int2bcd(t % modv)};
        end
        t = av - bv + modv;
        return {1'b0, (av >= bv), int2bcd(t % modv)};
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // driver
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int guard = 0;
        int k;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        @(posedge clk);
        #1;
        k = cyc;
        exp_q.push_back(model(a, b, sub));
        lat_q.push_back(k + ((has_bad(a) || has_bad(b)) ? 1 : NDIG));
        req_valid = 1'b0;
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        req_sub   = 1'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() > 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #2;
        rsp_ready = r;
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        if (bp_rand) rsp_ready = 1'($urandom_range(0, 1));
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            prev_v <= 1'b0;
        end else begin
            if (rsp_valid && !prev_v) begin
                if (lat_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
                else check("latency", 64'(cyc), 64'(lat_q.pop_front()));
            end
            prev_v <= rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", 64'({rsp_err, rsp_cout, rsp_sum}), 64'(e));
                end
            end
        end
    end

    // main sequence
    initial begin
        int g;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_word", 64'({rsp_err, rsp_cout, rsp_sum}), 64'd0);
        rst_n = 1'b1;

        send(16'h0456, 16'h0789, 1'b0);
        send(16'h9999, 16'h0001, 1'b0);
        send(16'h0100, 16'h0001, 1'b1);
        send(16'h0001, 16'h0002, 1'b1);
        send(16'h00A0, 16'h0001, 1'b0);
        drain();

        // backpressure: result must stay put while the consumer stalls
        set_ready(1'b0);
        send(16'h0456, 16'h0789, 1'b0);
        g = 0;
        while (!rsp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("bp_valid_seen", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum", 64'(rsp_sum), 64'h1245);
            check("bp_cout", 64'(rsp_cout), 64'd0);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_valid_hold", 64'(rsp_valid), 64'd1);
        end
        set_ready(1'b1);
        drain();
        @(negedge clk);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);

        // reset in the middle of a run discards the result
        send(16'h1234, 16'h5678, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        lat_q.delete();
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rsp_word", 64'({rsp_err, rsp_cout, rsp_sum}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NDIG + 3; i++) begin
            @(negedge clk);
            check("no_valid_after_rst", 64'(rsp_valid), 64'd0);
        end

        // random traffic with random backpressure
        bp_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = rand_bcd();
            b = rand_bcd();
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) a[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
                else b[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
            end
            send(a, b, 1'($urandom_range(0, 1)));
        end
        bp_rand = 1'b0;
        set_ready(1'b1);
        drain();
        check("lat_q_empty", 64'(lat_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
